// File: rtl/audio_sfx_arbiter.sv
// Fixed-priority sound-effect arbiter feeding the audio_out PCM register.
// Lowest index wins; playback is paced by an internal sample-rate tick.
//
// Ports:
//   ACLK, ARESETN   clock, synchronous active-low reset
//   req_i           per-source playback request (level)
//   smp_data_i      packed samples, source i at [i*SAMPLE_W +: SAMPLE_W]
//   smp_valid_i     per-source sample valid
//   smp_last_i      per-source final-sample flag
//   smp_ready_o     per-source sample consumed strobe
//   grant_o         one-hot current owner, zero when idle
//   preempt_o       pulse on the source that lost the grant
//   tick_o          sample-rate strobe
//   dac_data_o      registered sample to the DAC
//   dac_load_o      pulse when dac_data_o is written
//   underrun_cnt_o  saturating count of starved ticks
module audio_sfx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SAMPLE_W = 16,
  parameter int CLK_DIV  = 2268,
  parameter int PREEMPT  = 1
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*SAMPLE_W-1:0] smp_data_i,
  input  logic [NUM_REQ-1:0]          smp_valid_i,
  input  logic [NUM_REQ-1:0]          smp_last_i,
  output logic [NUM_REQ-1:0]          smp_ready_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [NUM_REQ-1:0]          preempt_o,
  output logic                        tick_o,
  output logic [SAMPLE_W-1:0]         dac_data_o,
  output logic                        dac_load_o,
  output logic [7:0]                  underrun_cnt_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {
    IDLE,
    PLAY
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  pre_q, pre_d;
  logic [SAMPLE_W-1:0] dac_q, dac_d;
  logic                load_q, load_d;
  logic [7:0]          urun_q, urun_d;

  logic                tick;
  logic [NUM_REQ-1:0]  below;
  logic                hi_req;
  logic                g_req;
  logic                g_valid;
  logic                g_last;
  logic [SAMPLE_W-1:0] g_data;

  function automatic logic [NUM_REQ-1:0] lowest(
    input logic [NUM_REQ-1:0] v
  );
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign tick = (div_q == DW'(CLK_DIV-1));

  // One-hot minus one sets every bit below
  // the owner: the requesters that outrank it.
  assign below  = grant_q - NUM_REQ'(1);
  assign hi_req = (PREEMPT != 0) &&
                  (|(req_i & below));

  assign g_req   = |(req_i & grant_q);
  assign g_valid = |(smp_valid_i & grant_q);
  assign g_last  = |(smp_last_i & grant_q);

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_data = smp_data_i[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pre_d   = '0;
    dac_d   = dac_q;
    load_d  = 1'b0;
    urun_d  = urun_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    unique case (state_q)
      IDLE: begin
        // Silence keeps the DAC fed while idle.
        if (tick) begin
          dac_d  = '0;
          load_d = 1'b1;
        end
        if (|req_i) begin
          grant_d = lowest(req_i);
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          dac_d  = '0;
          load_d = 1'b1;
          if (hi_req) begin
            grant_d = lowest(req_i);
            pre_d   = grant_q;
          end else if (!g_req) begin
            grant_d = '0;
            state_d = IDLE;
          end else if (g_valid) begin
            dac_d = g_data;
            if (g_last) begin
              grant_d = '0;
              state_d = IDLE;
            end
          end else if (urun_q != 8'hFF) begin
            urun_d = urun_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      div_q   <= '0;
      grant_q <= '0;
      pre_q   <= '0;
      dac_q   <= '0;
      load_q  <= 1'b0;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      grant_q <= grant_d;
      pre_q   <= pre_d;
      dac_q   <= dac_d;
      load_q  <= load_d;
      urun_q  <= urun_d;
    end
  end

  // A preempting tick consumes nothing;
  // an abandoning owner still sees ready.
  assign smp_ready_o =
    (tick && state_q == PLAY && !hi_req) ?
    grant_q : '0;

  assign grant_o        = grant_q;
  assign preempt_o      = pre_q;
  assign tick_o         = tick;
  assign dac_data_o     = dac_q;
  assign dac_load_o     = load_q;
  assign underrun_cnt_o = urun_q;

endmodule

// File: tb/tb_audio_sfx_arbiter.sv
// Scoreboard bench for audio_sfx_arbiter.
// Second instance runs with preemption disabled.
module tb_audio_sfx_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int DIV = 8;

  logic         ACLK    = 1'b0;
  logic         ARESETN = 1'b0;
  logic [N-1:0] req_i       = '0;
  logic [N-1:0] smp_valid_i = '0;
  logic [N-1:0] smp_last_i  = '0;
  logic [N*W-1:0] smp_data_i = '0;

  logic [N-1:0] smp_ready_o, grant_o, preempt_o;
  logic         tick_o, dac_load_o;
  logic [W-1:0] dac_data_o;
  logic [7:0]   underrun_cnt_o;

  logic [N-1:0] np_ready, np_grant, np_pre;
  logic         np_tick, np_load;
  logic [W-1:0] np_data;
  logic [7:0]   np_urun;

  audio_sfx_arbiter #(
    .NUM_REQ(N), .SAMPLE_W(W),
    .CLK_DIV(DIV), .PREEMPT(1)
  ) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_i(req_i), .smp_data_i(smp_data_i),
    .smp_valid_i(smp_valid_i),
    .smp_last_i(smp_last_i),
    .smp_ready_o(smp_ready_o),
    .grant_o(grant_o), .preempt_o(preempt_o),
    .tick_o(tick_o), .dac_data_o(dac_data_o),
    .dac_load_o(dac_load_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  audio_sfx_arbiter #(
    .NUM_REQ(N), .SAMPLE_W(W),
    .CLK_DIV(DIV), .PREEMPT(0)
  ) u_np (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_i(req_i), .smp_data_i(smp_data_i),
    .smp_valid_i(smp_valid_i),
    .smp_last_i(smp_last_i),
    .smp_ready_o(np_ready),
    .grant_o(np_grant), .preempt_o(np_pre),
    .tick_o(np_tick), .dac_data_o(np_data),
    .dac_load_o(np_load),
    .underrun_cnt_o(np_urun)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Monitor: every accepted sample must match the
  // queue head and appear on the DAC one cycle later.
  initial begin : mon
    logic         pend;
    logic [W-1:0] pdata;
    exp_t         e;
    pend  = 1'b0;
    pdata = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("sb_load", 32'(dac_load_o), 1);
          chk("sb_data", 32'(dac_data_o), 32'(pdata));
          pend = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (smp_ready_o[i] && smp_valid_i[i] &&
              req_i[i]) begin
            if (sbq.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL sb_unexpected: src %0d data %h expected none",
                       i, smp_data_i[i*W +: W]);
            end else begin
              e = sbq.pop_front();
              chk("sb_src", 32'(i), 32'(e.idx));
              pdata = e.data;
              pend  = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic set_req(input logic [N-1:0] r);
    @(posedge ACLK);
    #1 req_i = r;
  endtask

  task automatic send(input int idx,
                      input logic [W-1:0] d,
                      input logic last);
    bit   got;
    exp_t e;
    got = 1'b0;
    @(posedge ACLK);
    #1;
    smp_valid_i[idx]        = 1'b1;
    smp_data_i[idx*W +: W]  = d;
    smp_last_i[idx]         = last;
    e.idx  = idx;
    e.data = d;
    sbq.push_back(e);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge ACLK);
      if (smp_ready_o[idx]) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: src %0d got no ready expected ready",
               idx);
      void'(sbq.pop_back());
    end
    @(posedge ACLK);
    #1;
    smp_valid_i[idx] = 1'b0;
    smp_last_i[idx]  = 1'b0;
  endtask

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge ACLK);
      if (tick_o) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: got no tick expected tick");
    end
  endtask

  task automatic do_reset();
    @(posedge ACLK);
    #1 ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  initial begin : stim
    int n;

    // 1. reset values and tick period
    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ready", 32'(smp_ready_o), 0);
    chk("rst_pre", 32'(preempt_o), 0);
    chk("rst_tick", 32'(tick_o), 0);
    chk("rst_dac", 32'(dac_data_o), 0);
    chk("rst_load", 32'(dac_load_o), 0);
    chk("rst_urun", 32'(underrun_cnt_o), 0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      n++;
      if (tick_o) break;
    end
    chk("first_tick", 32'(n), 8);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      n++;
      if (tick_o) break;
    end
    chk("tick_period", 32'(n), 8);

    // 2. single source
    set_req(4'b0100);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("single_grant", 32'(grant_o), 32'h4);
    send(2, 16'h1111, 1'b0);
    send(2, 16'h2222, 1'b0);
    send(2, 16'h3333, 1'b1);
    req_i = '0;
    @(negedge ACLK);
    chk("single_idle", 32'(grant_o), 0);

    // 3. priority and back-to-back regrant
    set_req(4'b1010);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("prio_grant", 32'(grant_o), 32'h2);
    send(1, 16'h4444, 1'b1);
    req_i = 4'b1000;
    @(negedge ACLK);
    chk("prio_gap", 32'(grant_o), 0);
    @(negedge ACLK);
    chk("prio_next", 32'(grant_o), 32'h8);
    send(3, 16'h5555, 1'b1);
    req_i = '0;

    // 5. underruns and saturation
    set_req(4'b0001);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("ur_grant", 32'(grant_o), 32'h1);
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      @(negedge ACLK);
      chk("ur_load", 32'(dac_load_o), 1);
      chk("ur_dac", 32'(dac_data_o), 0);
    end
    chk("ur_cnt3", 32'(underrun_cnt_o), 3);
    for (int k = 0; k < 297; k++) wait_tick();
    @(negedge ACLK);
    chk("ur_sat", 32'(underrun_cnt_o), 255);
    set_req(4'b0000);
    wait_tick();
    @(negedge ACLK);
    chk("abandon_idle", 32'(grant_o), 0);
    chk("ur_hold", 32'(underrun_cnt_o), 255);

    // 4. preemption vs run-to-completion
    set_req(4'b0100);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("pre_grant", 32'(grant_o), 32'h4);
    send(2, 16'h0AAA, 1'b0);
    smp_valid_i[2]     = 1'b1;
    smp_data_i[2*W +: W] = 16'h0BBB;
    smp_last_i[2]      = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 req_i[0] = 1'b1;
    wait_tick();
    chk("pre_ready", 32'(smp_ready_o), 0);
    chk("np_ready", 32'(np_ready), 32'h4);
    @(negedge ACLK);
    chk("pre_pulse", 32'(preempt_o), 32'h4);
    chk("pre_dac", 32'(dac_data_o), 0);
    chk("pre_load", 32'(dac_load_o), 1);
    chk("pre_newgnt", 32'(grant_o), 32'h1);
    chk("np_pulse", 32'(np_pre), 0);
    chk("np_dac", 32'(np_data), 32'h0BBB);
    chk("np_done", 32'(np_grant), 0);
    @(negedge ACLK);
    chk("pre_oneshot", 32'(preempt_o), 0);
    chk("np_regrant", 32'(np_grant), 32'h1);
    req_i       = '0;
    smp_valid_i = '0;
    smp_last_i  = '0;
    do_reset();

    // 6. reset mid-playback
    set_req(4'b0010);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_grant", 32'(grant_o), 32'h2);
    send(1, 16'h6666, 1'b0);
    smp_valid_i[1]       = 1'b1;
    smp_data_i[1*W +: W] = 16'h7777;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_rst_gnt", 32'(grant_o), 0);
    chk("mid_rst_rdy", 32'(smp_ready_o), 0);
    chk("mid_rst_dac", 32'(dac_data_o), 0);
    chk("mid_rst_ld", 32'(dac_load_o), 0);
    @(posedge ACLK);
    #1;
    smp_valid_i = '0;
    ARESETN     = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_regrant", 32'(grant_o), 32'h2);
    req_i = '0;
    wait_tick();
    @(negedge ACLK);
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
